rr_arb_mux_4ch: RTL and testbench
=================================

# rr_arb_mux_4ch

Four-channel round-robin arbitrating multiplexer. Each of four W-bit sources presents data under a valid/ready handshake. The block picks one requesting channel per transfer with fair rotating priority and registers the winner's data together with its 2-bit channel index. It sits upstream of the datapath 4:1 selection stage and drives it: `out_sel` is the select code, and `out_data` is the already-selected word for consumers that take the merged stream directly.

## Interface
- `W`, default 4: data width of every channel and of `out_data`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  4  bit i set: channel i presents a word.
- `d0`, `d1`, `d2`, `d3`  in  W each  channel data.
- `in_ready`  out  4  one-hot or zero; bit i set means channel i is accepted this cycle.
- `out_valid`  out  1  the output register holds a word.
- `out_data`  out  W  registered winning word.
- `out_sel`  out  2  index of the channel that supplied `out_data`.
- `out_ready`  in  1  the consumer takes the word this cycle.

## Operation
- The output register has two states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `load` = (EMPTY or `out_ready`) and |`in_valid`.
- Grant:
  - Priority order starts at `last`+1 modulo 4 and wraps. For example, `last`=2 gives order 3, 0, 1, 2.
  - The first channel in that order with `in_valid` set wins.
  - `in_ready[g]`=1 only when `load` is true. All other bits are 0.
- On `load`:
  - `out_data` takes d[g], `out_sel` takes g, and `out_valid` is set to 1.
  - `last` takes g.
- `out_ready` with no `load`: FULL goes to EMPTY, and `out_data`/`out_sel` hold their values.
- FULL with no `out_ready`: `in_ready` is 0; everything holds. Back-pressure is total.
- Simultaneous drain and load in FULL: the new word replaces the old one in the same edge, with no bubble. Sustained throughput is 1 word/cycle.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and `last`. There is no combinational path from any d input to any output.
- Sources must hold `in_valid` and data until they are accepted. The block does not check this.
- A non-requesting channel never advances `last`. Fairness: a continuously requesting channel waits at most 3 grants.
- `out_valid` and `out_sel` must never produce X after reset, including when `in_valid` is 0.

## Timing
- Reset values, applied at the first rising edge with `rst`=1:
  - `out_valid`=0, `out_data`=0, `out_sel`=0.
  - `last`=3, so channel 0 has first priority.
  - `in_ready`=0 while `rst` is high.
- Reset mid-operation: a held word is discarded. No transfer completes in the reset cycle even if `in_valid`/`out_ready` are high.
- Latency: a word accepted at edge N appears on `out_data` after edge N. That is 1 cycle of input-to-output latency.
- A transfer occurs on a side only in a cycle where valid and ready are both high at the rising edge.

## Structure
- Shared package `arb_pkg`:
  - Typedef `ch_idx_t` = logic [1:0].
  - Constant `N_CH`=4.
  - Constant `RST_LAST`=2'd3.
- Natural sub-module: `rr_pick4`. It is purely combinational.
  - Inputs: `req`[3:0], `last`.
  - Outputs: `grant_idx`, `any`.
  - This isolates the rotating-priority logic for standalone unit test.
- The top level holds `last`, the output register, the state, and an indexed/if-chain data select.
- Expected size: about 150 RTL lines.

## Test plan
1. Reset and idle:
   - Drive `rst`=1 for 2 cycles with `in_valid`=4'hF.
   - Required: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_sel`=0.
2. Full rotation:
   - After reset, hold `in_valid`=4'hF, `out_ready`=1, and d0..d3 = 4'hA, 4'hB, 4'hC, 4'hD.
   - Required: `out_sel` sequence 0,1,2,3,0,… and `out_data` A,B,C,D,A, one word per cycle with no gaps.
3. Sparse skip:
   - Channel 1 is granted last; then apply `in_valid`=4'b1001.
   - Required: channel 3 wins next (`out_sel`=3), then channel 0.
4. Back-pressure:
   - Set `out_ready`=0 while FULL with `out_data`=4'h5 for 4 cycles.
   - Required: `in_ready`=0 and `out_data`/`out_sel` stable.
   - Then raise `out_ready`: the next grant follows in the same edge.
5. Single source:
   - Apply `in_valid`=4'b0100 only, with d2 incrementing 0..15.
   - Required: 16 consecutive outputs with `out_sel`=2 and data 0..15 in order.
6. Reset mid-stream:
   - Assert `rst` while FULL with `in_valid`=4'hF.
   - Required: next cycle `out_valid`=0; after release, the first grant goes to channel 0.

Source files
------------

// File: rtl/rr_arb_mux_4ch_pkg.sv
// Shared types and constants for the four-channel round-robin arbitrating mux.
package arb_pkg;

  typedef logic [1:0] ch_idx_t;

  localparam int      N_CH     = 4;
  localparam ch_idx_t RST_LAST = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb_mux_4ch_pick4.sv
// Rotating-priority picker: first requester after 'last' (wrapping) wins.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  ch_idx_t    last,
  output ch_idx_t    grant_idx,
  output logic       any
);

  // Walk the four candidates starting one past 'last'; k=4 wraps back to 'last'.
  always_comb begin
    ch_idx_t cand;
    logic    found;
    grant_idx = '0;
    any       = |req;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = last + ch_idx_t'(k);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux_4ch.sv
// Four-channel round-robin arbitrating mux with a single registered output slot.
module rr_arb_mux_4ch
  import arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output ch_idx_t      out_sel,
  input  logic         out_ready
);

  state_t       state_q, state_d;
  ch_idx_t      last_q, last_d;
  logic [W-1:0] data_q, data_d;
  ch_idx_t      sel_q, sel_d;

  ch_idx_t      grant;
  logic         any_req;
  logic         load;
  logic [W-1:0] grant_data;

  rr_pick4 u_pick (
    .req       (in_valid),
    .last      (last_q),
    .grant_idx (grant),
    .any       (any_req)
  );

  // A slot can accept when empty or being drained this cycle; reset blocks all transfers.
  assign load = !rst && ((state_q == ST_EMPTY) || out_ready) && any_req;

  always_comb begin
    in_ready = 4'b0000;
    if (load) in_ready[grant] = 1'b1;
  end

  always_comb begin
    case (grant)
      2'd0:    grant_data = d0;
      2'd1:    grant_data = d1;
      2'd2:    grant_data = d2;
      default: grant_data = d3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load) begin
      state_d = ST_FULL;
      data_d  = grant_data;
      sel_d   = grant;
      last_d  = grant;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      last_q  <= RST_LAST;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux_4ch.sv
// Self-checking bench for rr_arb_mux_4ch: directed scenarios plus random traffic vs. a behavioural model.
module tb_rr_arb_mux_4ch;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the output slot and rotation pointer.
  logic         chkEn = 1'b0;
  logic         mValid = 1'b0;
  int           mData = 0;
  int           mSel = 0;
  int           mLast = 3;

  rr_arb_mux_4ch #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int grantOf(input int last, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic int dataOf(input int ch);
    case (ch)
      0:       return int'(d0);
      1:       return int'(d1);
      2:       return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  function automatic logic [3:0] expReady();
    int g;
    logic [3:0] r;
    r = 4'b0000;
    g = grantOf(mLast, in_valid);
    if (!rst && (!mValid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one clock; inputs are changed only at posedge+1 so they are stable at both edges.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic ordy);
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mValid = 1'b0;
      mData  = 0;
      mSel   = 0;
      mLast  = 3;
      chkEn  = 1'b1;
    end else if (chkEn) begin
      int g;
      g = grantOf(mLast, in_valid);
      if ((!mValid || out_ready) && g >= 0) begin
        mValid = 1'b1;
        mData  = dataOf(g);
        mSel   = g;
        mLast  = g;
      end else if (out_ready) begin
        mValid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("model in_ready", 32'(in_ready), 32'(expReady()));
      checkOutput("model out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("model out_sel", 32'(out_sel), 32'(mSel));
      checkOutput("model out_data", 32'(out_data), 32'(mData));
    end
  end

  initial begin
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;

    // Reset with all channels requesting
    applyStimulus(1'b1, 4'hF, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("reset in_ready", 32'(in_ready), 32'h0);
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset out_data", 32'(out_data), 32'h0);
    checkOutput("reset out_sel", 32'(out_sel), 32'h0);

    // Full rotation at one word per cycle
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'hF, 1'b1);
      checkOutput("rot valid", 32'(out_valid), 32'h1);
      checkOutput("rot sel", 32'(out_sel), 32'(i % 4));
      checkOutput("rot data", 32'(out_data), 32'(32'hA + (i % 4)));
    end

    // Sparse skip: after channel 1, 1001 goes to 3 then 0
    applyStimulus(1'b0, 4'b0010, 1'b1);
    checkOutput("skip pre sel", 32'(out_sel), 32'h1);
    applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("skip sel3", 32'(out_sel), 32'h3);
    checkOutput("skip data3", 32'(out_data), 32'hD);
    applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("skip sel0", 32'(out_sel), 32'h0);

    // Back-pressure on a held 5 from channel 1
    d1 = 4'h5;
    applyStimulus(1'b0, 4'b0010, 1'b1);
    checkOutput("bp load data", 32'(out_data), 32'h5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'hF, 1'b0);
      checkOutput("bp in_ready", 32'(in_ready), 32'h0);
      checkOutput("bp data", 32'(out_data), 32'h5);
      checkOutput("bp sel", 32'(out_sel), 32'h1);
      checkOutput("bp valid", 32'(out_valid), 32'h1);
    end
    rst = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 32'(in_ready), 32'b0100);
    @(posedge clk); #1;
    checkOutput("bp release sel", 32'(out_sel), 32'h2);
    checkOutput("bp release data", 32'(out_data), 32'hC);

    // Single source with incrementing data
    for (int i = 0; i < 16; i++) begin
      d2 = 4'(i);
      applyStimulus(1'b0, 4'b0100, 1'b1);
      checkOutput("single sel", 32'(out_sel), 32'h2);
      checkOutput("single data", 32'(out_data), 32'(i));
    end

    // Reset while full
    d2 = 4'hC;
    applyStimulus(1'b0, 4'hF, 1'b0);
    checkOutput("mid full", 32'(out_valid), 32'h1);
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("mid rst valid", 32'(out_valid), 32'h0);
    checkOutput("mid rst in_ready", 32'(in_ready), 32'h0);
    applyStimulus(1'b0, 4'hF, 1'b1);
    checkOutput("mid first sel", 32'(out_sel), 32'h0);
    checkOutput("mid first data", 32'(out_data), 32'hA);

    // Random traffic checked by the model process
    for (int i = 0; i < 400; i++) begin
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      applyStimulus(($urandom_range(0, 39) == 0), 4'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    applyStimulus(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
